ddr_refresh_scheduler: RTL and testbench
========================================

// Module: ddr_refresh_scheduler
// PURPOSE
//  Sequences DDR4 auto-refresh around read/write traffic. Tracks the tREFI interval and postponed-refresh debt.
//  Holds off the rw engine and issues REF commands, with handshakes, to the command path. Owns the tRFC window.
//  Sits between the top-level controller FSM and the command bus arbiter.
// PARAMETERS
//  T_REFI        7800  refresh interval in clock_t cycles (>=16)
//  T_RFC         350   refresh cycle time in cycles (>=2)
//  MAX_POSTPONE  8     refreshes that may be deferred (1..14)
// PORTS
//  clock_t       in   1  controller clock
//  reset         in   1  synchronous, active-high reset
//  enable        in   1  init/config done; interval counting runs while high
//  rw_pending    in   1  rw engine has queued requests (postpone when possible)
//  rw_idle       in   1  rw engine has no burst in flight
//  rw_hold       out  1  stop issuing new bursts
//  ref_req       out  1  REF command valid
//  ref_ack       in   1  REF accepted by command bus (single-cycle)
//  ref_busy      out  1  inside tRFC window
//  debt          out  4  outstanding (postponed) refreshes
//  overflow_err  out  1  sticky: debt would exceed MAX_POSTPONE+1
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; interval, rfc counters 0; debt 0; credit 0.
//  Interval counter: while enable=1, counts 0..T_REFI-1 and wraps. The wrap cycle is a "tick".
//   Cleared and held at 0 while enable=0.
//  Tick: if credit>0 then credit-1 else debt+1. Debt saturates at MAX_POSTPONE+1.
//   A tick at saturation sets overflow_err; it clears only on reset.
//  Simultaneous tick and ref_ack: net debt unchanged. No glitch is visible on the debt output.
//  Urgent = debt>=MAX_POSTPONE.
//  FSM:
//   IDLE  : enable=1 -> RUN.
//   RUN   : debt>0 and (!rw_pending or urgent) -> DRAIN. enable=0 -> IDLE (debt/credit cleared).
//   DRAIN : rw_hold=1. rw_idle=1 -> ISSUE (decision at same edge). enable=0 -> IDLE.
//   ISSUE : rw_hold=1, ref_req=1 held until ref_ack.
//           On ack: debt-1 (or credit+1 for a pull-in); rfc counter=T_RFC-1; -> RFC.
//   RFC   : rw_hold=1, ref_busy=1; counts down to 0. At 0:
//           enable=0 -> IDLE. Else debt>0 and (urgent or !rw_pending) -> ISSUE (back-to-back, no drain).
//           Otherwise -> RUN.
//  rw_hold, ref_req, ref_busy are registered decodes of state. ref_req first rises 1 cycle after rw_idle is seen in DRAIN.
//  ref_busy is high for exactly T_RFC cycles per REF.
//  ref_ack outside ISSUE is ignored.
//  enable falling during ISSUE/RFC: the current REF completes, then -> IDLE.
// CONFIGURATION
//  REFRESH_PULLIN_EN defined: in RUN with debt=0, !rw_pending, rw_idle and credit<MAX_POSTPONE, -> ISSUE.
//   The ack of that REF increments credit (pull-in refresh). Later ticks consume credit before adding debt.
//  Undefined: credit is tied to 0. Refresh is issued only when debt>0.
// TESTING (T_REFI=100, T_RFC=10, MAX_POSTPONE=4; ack 1 cycle after ref_req)
//  Idle traffic: enable=1, rw_pending=0, rw_idle=1 -> first ref_req at cycle ~101; debt returns 0; ref_busy 10 cycles.
//  Postpone: rw_pending=1 throughout -> debt counts 1,2,3,4. At debt=4, rw_hold rises and REF issues back-to-back until debt=0.
//   This is 4 REFs, ~11 cycles apart.
//  Overflow: rw_pending=1, rw_idle=0 forever -> debt saturates at 5, overflow_err=1 at the 6th tick and stays set.
//  Tick+ack same cycle: force ack on the tick edge with debt=2 -> debt stays 2.
//  Mid-op: enable=0 during RFC -> ref_busy completes 10 cycles, then IDLE. Reset mid-RFC -> all outputs 0 next cycle.
//  REFRESH_PULLIN_EN, idle -> REF issued with debt=0, credit=1. Next tick leaves debt=0, credit=0.

Source files
------------

// File: rtl/ddr_refresh_scheduler.sv
// ddr_refresh_scheduler
//   Schedules DDR4 auto-refresh around read/write traffic. Counts the tREFI
//   interval, keeps the postponed-refresh debt, holds off the rw engine,
//   issues REF commands with a valid/ack handshake and owns the tRFC window.
//
// Ports
//   clock_t       in   controller clock
//   reset         in   synchronous active-high reset
//   enable        in   init/config done; interval counting runs while high
//   rw_pending    in   rw engine has queued requests (refresh is postponed)
//   rw_idle       in   rw engine has no burst in flight
//   rw_hold       out  stop issuing new bursts (DRAIN/ISSUE/RFC)
//   ref_req       out  REF command valid, held until ref_ack
//   ref_ack       in   REF accepted by the command bus (single cycle)
//   ref_busy      out  inside the tRFC window (exactly T_RFC cycles per REF)
//   debt          out  outstanding (postponed) refreshes
//   overflow_err  out  sticky: a tick arrived with debt already saturated
//
// Optional feature macro: REFRESH_PULLIN_EN
//   Defined   : idle periods issue pull-in refreshes that bank credit.
//   Undefined : credit is tied to 0; REF only issues when debt > 0.

module ddr_refresh_scheduler #(
    parameter int T_REFI       = 7800,
    parameter int T_RFC        = 350,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       clock_t,
    input  logic       reset,
    input  logic       enable,
    input  logic       rw_pending,
    input  logic       rw_idle,
    output logic       rw_hold,
    output logic       ref_req,
    input  logic       ref_ack,
    output logic       ref_busy,
    output logic [3:0] debt,
    output logic       overflow_err
);

    localparam int IW = $clog2(T_REFI);
    localparam int RW = $clog2(T_RFC);
    localparam logic [IW-1:0] REFI_LAST   = IW'(T_REFI - 1);
    localparam logic [RW-1:0] RFC_LOAD    = RW'(T_RFC - 1);
    localparam logic [3:0]    DEBT_SAT    = 4'(MAX_POSTPONE + 1);
    localparam logic [3:0]    DEBT_URGENT = 4'(MAX_POSTPONE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ISSUE = 3'd3,
        ST_RFC   = 3'd4
    } state_t;

    state_t          state_r, next_state_s;
    logic [IW-1:0]   interval_r;
    logic [RW-1:0]   rfc_r;
    logic [3:0]      debt_r, debt_nx_s;
    logic [3:0]      credit_r, credit_nx_s;
    logic            flush_r, flush_nx_s;
    logic            ovf_r, ovf_set_s;
    logic            tick_s, ack_s, urgent_s, pullin_s, leave_idle_s;
    logic            rw_hold_s, ref_req_s, ref_busy_s;
    logic            rw_hold_r, ref_req_r, ref_busy_r;

    assign tick_s = enable && (interval_r == REFI_LAST);
    assign ack_s  = (state_r == ST_ISSUE) && ref_ack;
    // Once debt reaches the postpone limit the whole backlog is flushed
    // back-to-back, even after debt drops below the limit again.
    assign urgent_s     = (debt_r >= DEBT_URGENT) || flush_r;
    assign leave_idle_s = (state_r != ST_IDLE) && (next_state_s == ST_IDLE);

`ifdef REFRESH_PULLIN_EN
    assign pullin_s = (debt_r == 4'd0) && !rw_pending && rw_idle && (credit_r < DEBT_URGENT);
`else
    assign pullin_s = 1'b0;
`endif

    // tREFI interval counter: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            interval_r <= '0;
        end else if (!enable || tick_s) begin
            interval_r <= '0;
        end else begin
            interval_r <= interval_r + IW'(1);
        end
    end

    // tRFC down-counter, loaded on the accepted REF.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            rfc_r <= '0;
        end else if (ack_s) begin
            rfc_r <= RFC_LOAD;
        end else if ((state_r == ST_RFC) && (rfc_r != '0)) begin
            rfc_r <= rfc_r - RW'(1);
        end else begin
            rfc_r <= rfc_r;
        end
    end

    // Debt/credit bookkeeping; a tick and an ack in the same cycle cancel.
    always_comb begin
        debt_nx_s   = debt_r;
        credit_nx_s = credit_r;
        ovf_set_s   = 1'b0;
        if (tick_s) begin
            if (credit_r != 4'd0) begin
                credit_nx_s = credit_r - 4'd1;
            end else if (debt_r != DEBT_SAT) begin
                debt_nx_s = debt_r + 4'd1;
            end else begin
                ovf_set_s = !ack_s;
            end
        end else begin
            debt_nx_s = debt_r;
        end
        if (ack_s) begin
            if (debt_nx_s != 4'd0) begin
                debt_nx_s = debt_nx_s - 4'd1;
            end else begin
                credit_nx_s = credit_nx_s + 4'd1;
            end
        end else begin
            credit_nx_s = credit_nx_s;
        end
        if (leave_idle_s) begin
            debt_nx_s   = 4'd0;
            credit_nx_s = 4'd0;
        end else begin
            debt_nx_s = debt_nx_s;
        end
`ifndef REFRESH_PULLIN_EN
        credit_nx_s = 4'd0;
`endif
        if (debt_nx_s >= DEBT_URGENT) begin
            flush_nx_s = 1'b1;
        end else if (debt_nx_s == 4'd0) begin
            flush_nx_s = 1'b0;
        end else begin
            flush_nx_s = flush_r;
        end
    end

    // Debt, credit, flush and sticky overflow registers.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            debt_r   <= 4'd0;
            credit_r <= 4'd0;
            flush_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            debt_r   <= debt_nx_s;
            credit_r <= credit_nx_s;
            flush_r  <= flush_nx_s;
            ovf_r    <= ovf_r | ovf_set_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) next_state_s = ST_RUN;
                else        next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable)                                         next_state_s = ST_IDLE;
                else if ((debt_r != 4'd0) && (!rw_pending || urgent_s)) next_state_s = ST_DRAIN;
                else if (pullin_s)                                   next_state_s = ST_ISSUE;
                else                                                 next_state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!enable)     next_state_s = ST_IDLE;
                else if (rw_idle) next_state_s = ST_ISSUE;
                else             next_state_s = ST_DRAIN;
            end
            ST_ISSUE: begin
                // The REF in flight always completes, even if enable drops.
                if (ref_ack) next_state_s = ST_RFC;
                else         next_state_s = ST_ISSUE;
            end
            ST_RFC: begin
                if (rfc_r != '0)                                      next_state_s = ST_RFC;
                else if (!enable)                                     next_state_s = ST_IDLE;
                else if ((debt_r != 4'd0) && (urgent_s || !rw_pending)) next_state_s = ST_ISSUE;
                else                                                  next_state_s = ST_RUN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state register.
    always_comb begin
        rw_hold_s  = 1'b0;
        ref_req_s  = 1'b0;
        ref_busy_s = 1'b0;
        case (next_state_s)
            ST_DRAIN: rw_hold_s = 1'b1;
            ST_ISSUE: begin
                rw_hold_s = 1'b1;
                ref_req_s = 1'b1;
            end
            ST_RFC: begin
                rw_hold_s  = 1'b1;
                ref_busy_s = 1'b1;
            end
            default: begin
                rw_hold_s  = 1'b0;
                ref_req_s  = 1'b0;
                ref_busy_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            rw_hold_r  <= 1'b0;
            ref_req_r  <= 1'b0;
            ref_busy_r <= 1'b0;
        end else begin
            rw_hold_r  <= rw_hold_s;
            ref_req_r  <= ref_req_s;
            ref_busy_r <= ref_busy_s;
        end
    end

    assign rw_hold      = rw_hold_r;
    assign ref_req      = ref_req_r;
    assign ref_busy     = ref_busy_r;
    assign debt         = debt_r;
    assign overflow_err = ovf_r;

endmodule

// File: tb/tb_ddr_refresh_scheduler.sv
// Directed testbench for ddr_refresh_scheduler with T_REFI=100, T_RFC=10,
// MAX_POSTPONE=4. Inputs change and outputs are sampled 1 time unit after
// each rising clock edge. cyc counts edges since enable was raised, so after
// cyc==k the DUT has seen edges E0..E(k-1) with enable high.

module tb_ddr_refresh_scheduler;

    logic       clock_t = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       rw_pending = 1'b0;
    logic       rw_idle = 1'b0;
    logic       rw_hold;
    logic       ref_req;
    logic       ref_ack = 1'b0;
    logic       ref_busy;
    logic [3:0] debt;
    logic       overflow_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic ack_auto = 1'b0;

    ddr_refresh_scheduler #(
        .T_REFI(100), .T_RFC(10), .MAX_POSTPONE(4)
    ) dut (
        .clock_t(clock_t), .reset(reset), .enable(enable),
        .rw_pending(rw_pending), .rw_idle(rw_idle), .rw_hold(rw_hold),
        .ref_req(ref_req), .ref_ack(ref_ack), .ref_busy(ref_busy),
        .debt(debt), .overflow_err(overflow_err)
    );

    always #5 clock_t = ~clock_t;

    // Command-bus model: acknowledges a REF one cycle after ref_req is seen.
    initial begin
        forever begin
            @(posedge clock_t);
            #1;
            if (ack_auto) ref_ack = ref_req;
        end
    end

    task automatic step();
        @(posedge clock_t);
        #1;
        cyc++;
    endtask

    task automatic begin_run(input logic pend, input logic idle, input logic auto);
        ack_auto = 1'b0;
        ref_ack = 1'b0;
        reset = 1'b1;
        enable = 1'b0;
        step();
        step();
        reset = 1'b0;
        rw_pending = pend;
        rw_idle = idle;
        ack_auto = auto;
        enable = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step(); step();
        total++; if (rw_hold !== 1'b0) begin bad++; $display("FAIL reset_rw_hold got %0b want 0", rw_hold); end
        total++; if (ref_req !== 1'b0) begin bad++; $display("FAIL reset_ref_req got %0b want 0", ref_req); end
        total++; if (ref_busy !== 1'b0) begin bad++; $display("FAIL reset_ref_busy got %0b want 0", ref_busy); end
        total++; if (debt !== 4'd0) begin bad++; $display("FAIL reset_debt got %0d want 0", debt); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got %0b want 0", overflow_err); end
    endtask

    task automatic test_idle_traffic();
        int busy_cnt;
        int guard;
        begin_run(1'b0, 1'b1, 1'b0);
        while (cyc < 50) step();
        // Stray ack outside ISSUE must be ignored.
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        total++; if (ref_busy !== 1'b0 || debt !== 4'd0) begin bad++; $display("FAIL stray_ack busy=%0b debt=%0d want 0/0", ref_busy, debt); end
        ack_auto = 1'b1;
        guard = 0;
        while (!ref_req && guard < 200) begin step(); guard++; end
        total++; if (cyc !== 102) begin bad++; $display("FAIL idle_first_req cyc got %0d want 102", cyc); end
        total++; if (debt !== 4'd1 || rw_hold !== 1'b1) begin bad++; $display("FAIL idle_req_state debt=%0d hold=%0b want 1/1", debt, rw_hold); end
        step();
        total++; if (ref_busy !== 1'b1 || debt !== 4'd0) begin bad++; $display("FAIL idle_ack busy=%0b debt=%0d want 1/0", ref_busy, debt); end
        busy_cnt = 0;
        while (ref_busy && busy_cnt < 30) begin busy_cnt++; step(); end
        total++; if (busy_cnt !== 10) begin bad++; $display("FAIL idle_busy_len got %0d want 10", busy_cnt); end
        total++; if (rw_hold !== 1'b0 || debt !== 4'd0) begin bad++; $display("FAIL idle_after hold=%0b debt=%0d want 0/0", rw_hold, debt); end
    endtask

    task automatic test_pullin();
        begin_run(1'b0, 1'b1, 1'b1);
        step(); step();
        total++; if (ref_req !== 1'b1 || debt !== 4'd0) begin bad++; $display("FAIL pullin_req req=%0b debt=%0d want 1/0", ref_req, debt); end
        while (cyc < 150) step();
        total++; if (debt !== 4'd0) begin bad++; $display("FAIL pullin_tick_debt got %0d want 0", debt); end
    endtask

    task automatic test_back_to_back();
        int rises;
        int last;
        int hold_cnt;
        logic prev_busy;
        begin_run(1'b1, 1'b1, 1'b1);
        while (cyc < 200) step();
        total++; if (debt !== 4'd2) begin bad++; $display("FAIL postpone_debt2 got %0d want 2", debt); end
        while (cyc < 400) step();
        total++; if (debt !== 4'd4 || rw_hold !== 1'b0) begin bad++; $display("FAIL postpone_debt4 debt=%0d hold=%0b want 4/0", debt, rw_hold); end
        step();
        total++; if (rw_hold !== 1'b1) begin bad++; $display("FAIL urgent_hold got %0b want 1", rw_hold); end
        step();
        total++; if (ref_req !== 1'b1) begin bad++; $display("FAIL urgent_req got %0b want 1", ref_req); end
        rises = 0; last = 0; hold_cnt = 0; prev_busy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (rw_hold) hold_cnt++;
            if (ref_busy && !prev_busy) begin
                total++; if (debt !== 4'(3 - rises)) begin bad++; $display("FAIL b2b_debt ref%0d got %0d want %0d", rises, debt, 3 - rises); end
                if (rises > 0) begin
                    total++; if (cyc - last !== 11) begin bad++; $display("FAIL b2b_gap got %0d want 11", cyc - last); end
                end
                last = cyc;
                rises++;
            end
            prev_busy = ref_busy;
        end
        total++; if (rises !== 4) begin bad++; $display("FAIL b2b_count got %0d want 4", rises); end
        total++; if (hold_cnt !== 43) begin bad++; $display("FAIL b2b_hold_len got %0d want 43", hold_cnt); end
        total++; if (debt !== 4'd0 || rw_hold !== 1'b0) begin bad++; $display("FAIL b2b_end debt=%0d hold=%0b want 0/0", debt, rw_hold); end
    endtask

    task automatic test_overflow();
        begin_run(1'b1, 1'b0, 1'b1);
        while (cyc < 500) step();
        total++; if (debt !== 4'd5 || overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_sat debt=%0d ovf=%0b want 5/0", debt, overflow_err); end
        total++; if (rw_hold !== 1'b1) begin bad++; $display("FAIL ovf_hold got %0b want 1", rw_hold); end
        while (cyc < 599) step();
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_early got %0b want 0", overflow_err); end
        step();
        total++; if (overflow_err !== 1'b1 || debt !== 4'd5) begin bad++; $display("FAIL ovf_set ovf=%0b debt=%0d want 1/5", overflow_err, debt); end
        while (cyc < 700) step();
        total++; if (overflow_err !== 1'b1 || debt !== 4'd5) begin bad++; $display("FAIL ovf_sticky ovf=%0b debt=%0d want 1/5", overflow_err, debt); end
    endtask

    // Continues from the saturated overflow state: release the rw engine,
    // then reset in the middle of the first tRFC window.
    task automatic test_reset_mid_rfc();
        int guard;
        rw_idle = 1'b1;
        guard = 0;
        while (!ref_busy && guard < 20) begin step(); guard++; end
        total++; if (ref_busy !== 1'b1 || debt !== 4'd4) begin bad++; $display("FAIL drain_ref busy=%0b debt=%0d want 1/4", ref_busy, debt); end
        step(); step(); step();
        total++; if (ref_busy !== 1'b1 || overflow_err !== 1'b1) begin bad++; $display("FAIL mid_rfc busy=%0b ovf=%0b want 1/1", ref_busy, overflow_err); end
        reset = 1'b1;
        step();
        total++; if ({rw_hold, ref_req, ref_busy, overflow_err} !== 4'b0000 || debt !== 4'd0) begin
            bad++; $display("FAIL reset_mid_rfc hold=%0b req=%0b busy=%0b ovf=%0b debt=%0d want all 0", rw_hold, ref_req, ref_busy, overflow_err, debt);
        end
        reset = 1'b0;
    endtask

    task automatic test_tick_ack();
        begin_run(1'b1, 1'b1, 1'b0);
        while (cyc < 251) step();
        total++; if (debt !== 4'd2) begin bad++; $display("FAIL tickack_pre_debt got %0d want 2", debt); end
        rw_pending = 1'b0;
        while (cyc < 299) step();
        total++; if (ref_req !== 1'b1 || debt !== 4'd2) begin bad++; $display("FAIL tickack_wait req=%0b debt=%0d want 1/2", ref_req, debt); end
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        total++; if (debt !== 4'd2 || ref_busy !== 1'b1) begin bad++; $display("FAIL tickack_debt debt=%0d busy=%0b want 2/1", debt, ref_busy); end
    endtask

    task automatic test_disable_mid_rfc();
        int busy_cnt;
        int guard;
        begin_run(1'b0, 1'b1, 1'b1);
        guard = 0;
        while (!ref_busy && guard < 200) begin step(); guard++; end
        enable = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ref_busy) busy_cnt++;
        end
        total++; if (busy_cnt !== 9) begin bad++; $display("FAIL disable_busy_rest got %0d want 9", busy_cnt); end
        total++; if (rw_hold !== 1'b0 || ref_req !== 1'b0) begin bad++; $display("FAIL disable_idle hold=%0b req=%0b want 0/0", rw_hold, ref_req); end
        for (int i = 0; i < 150; i++) step();
        total++; if (debt !== 4'd0 || ref_req !== 1'b0 || rw_hold !== 1'b0) begin bad++; $display("FAIL disable_held debt=%0d req=%0b hold=%0b want 0/0/0", debt, ref_req, rw_hold); end
    endtask

    initial begin
        test_reset();
`ifdef REFRESH_PULLIN_EN
        test_pullin();
`else
        test_idle_traffic();
`endif
        test_back_to_back();
        test_overflow();
        test_reset_mid_rfc();
        test_tick_ack();
        test_disable_mid_rfc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
